segre_store_buffer: RTL and testbench

- Small FIFO of committed stores between the MEM stage and the data cache write port.
- Stores that hit the cache are absorbed in one cycle and written to the cache later, when the port is idle.
- Loads in MEM check the buffer: a fully covering match is forwarded; any other match forces a drain.
- Drives draining_o into the pipeline controller's store_buffer_draining_i, which blocks MEM and injects NOPs into WB while asserted.

---
 rtl/segre_store_buffer.sv | 141 ++++++++++++++
 tb/tb_segre_store_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_store_buffer.sv
// Store buffer between MEM and the data-cache write port: absorbs hit stores,
// forwards covering loads and drains to the cache when the port is free.
module segre_store_buffer #(
  parameter int DEPTH     = 2,
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
) (
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  logic                   valid_mem_i,
  input  logic                   dc_wr_i,
  input  logic                   dc_rd_i,
  input  logic                   dc_hit_i,
  input  logic                   block_mem_i,
  input  logic [ADDR_SIZE-1:0]   addr_i,
  input  logic [WORD_SIZE-1:0]   data_i,
  input  logic [WORD_SIZE/8-1:0] be_i,
  input  logic                   flush_i,
  output logic                   drain_valid_o,
  output logic [ADDR_SIZE-1:0]   drain_addr_o,
  output logic [WORD_SIZE-1:0]   drain_data_o,
  output logic [WORD_SIZE/8-1:0] drain_be_o,
  input  logic                   drain_ready_i,
  output logic                   ld_fwd_o,
  output logic [WORD_SIZE-1:0]   ld_data_o,
  output logic                   draining_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int BE_W  = WORD_SIZE / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_SIZE - 2;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  logic [WA_W-1:0]      ent_addr [DEPTH];
  logic [WORD_SIZE-1:0] ent_data [DEPTH];
  logic [BE_W-1:0]      ent_be   [DEPTH];

  ptr_t head_q, tail_q, young, fwd_idx, scan_idx;
  cnt_t count_q;
  logic flush_pend_q;

  logic [WA_W-1:0] wa;
  logic st, ld, empty, full;
  logic merge_cand, do_merge, do_push, pop, young_pop;
  logic fwd_hit, fwd_cover, ld_conflict, full_stall, flush_drain;
  logic unused_addr_lsb;

  function automatic logic [WORD_SIZE-1:0] merge_lanes(
    input logic [WORD_SIZE-1:0] old_w,
    input logic [WORD_SIZE-1:0] new_w,
    input logic [BE_W-1:0]      be
  );
    logic [WORD_SIZE-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign wa              = addr_i[ADDR_SIZE-1:2];
  assign unused_addr_lsb = ^addr_i[1:0];

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);
  assign young = tail_q - ptr_t'(1);

  // A zero-mask store writes nothing, so it is not worth an entry.
  assign st = valid_mem_i & dc_wr_i & dc_hit_i & ~block_mem_i & (be_i != '0);
  assign ld = valid_mem_i & dc_rd_i;

  // Oldest-to-youngest scan so the last match wins (youngest data).
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_idx  = head_q;
    scan_idx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_q + ptr_t'(k);
      if ((cnt_t'(k) < count_q) && (ent_addr[scan_idx] == wa)) begin
        fwd_hit = 1'b1;
        fwd_idx = scan_idx;
      end
    end
  end

  assign fwd_cover   = ((ent_be[fwd_idx] & be_i) == be_i);
  assign ld_fwd_o    = ld & fwd_hit & fwd_cover;
  assign ld_conflict = ld & fwd_hit & ~fwd_cover;
  assign ld_data_o   = ld_fwd_o ? ent_data[fwd_idx] : '0;

  // Stall terms avoid drain_ready_i so the cache handshake stays loop-free.
  assign merge_cand  = st & ~empty & (ent_addr[young] == wa);
  assign full_stall  = st & full & ~merge_cand;
  assign flush_drain = flush_pend_q & ~empty;
  assign draining_o  = full_stall | ld_conflict | flush_drain;

  assign drain_valid_o = ~empty & (~ld | draining_o);
  assign pop           = drain_valid_o & drain_ready_i;
  assign young_pop     = pop & (count_q == cnt_t'(1));
  assign do_merge      = merge_cand & ~young_pop;
  assign do_push       = st & ~full & ~flush_pend_q & ~do_merge;

  assign drain_addr_o = drain_valid_o ? {ent_addr[head_q], 2'b00} : '0;
  assign drain_data_o = drain_valid_o ? ent_data[head_q] : '0;
  assign drain_be_o   = drain_valid_o ? ent_be[head_q] : '0;
  assign full_o       = full;
  assign empty_o      = empty;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (do_push) tail_q <= tail_q + ptr_t'(1);
      if (pop)     head_q <= head_q + ptr_t'(1);
      count_q <= count_q + cnt_t'(do_push) - cnt_t'(pop);
      if (flush_i && !empty) flush_pend_q <= 1'b1;
      else if (empty)        flush_pend_q <= 1'b0;
    end
  end

  // Entry payload carries no reset; validity comes from head/count alone.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      ent_addr[tail_q] <= wa;
      ent_data[tail_q] <= data_i;
      ent_be[tail_q]   <= be_i;
    end else if (do_merge) begin
      ent_data[young] <= merge_lanes(ent_data[young], data_i, be_i);
      ent_be[young]   <= ent_be[young] | be_i;
    end
  end

endmodule

// File: tb/tb_segre_store_buffer.sv
// Directed bench for segre_store_buffer: a per-cycle vector table plus
// hand-written sequences for full/merge, flush, reset and pointer wrap.
module tb_segre_store_buffer;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        valid_mem_i, dc_wr_i, dc_rd_i, dc_hit_i, block_mem_i;
  logic [31:0] addr_i, data_i;
  logic [3:0]  be_i;
  logic        flush_i;
  logic        drain_valid_o;
  logic [31:0] drain_addr_o, drain_data_o;
  logic [3:0]  drain_be_o;
  logic        drain_ready_i;
  logic        ld_fwd_o;
  logic [31:0] ld_data_o;
  logic        draining_o, full_o, empty_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  segre_store_buffer #(.DEPTH(2), .ADDR_SIZE(32), .WORD_SIZE(32)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .valid_mem_i(valid_mem_i), .dc_wr_i(dc_wr_i), .dc_rd_i(dc_rd_i),
    .dc_hit_i(dc_hit_i), .block_mem_i(block_mem_i),
    .addr_i(addr_i), .data_i(data_i), .be_i(be_i), .flush_i(flush_i),
    .drain_valid_o(drain_valid_o), .drain_addr_o(drain_addr_o),
    .drain_data_o(drain_data_o), .drain_be_o(drain_be_o),
    .drain_ready_i(drain_ready_i),
    .ld_fwd_o(ld_fwd_o), .ld_data_o(ld_data_o),
    .draining_o(draining_o), .full_o(full_o), .empty_o(empty_o)
  );

  typedef struct {
    int          op;      // 0 idle, 1 store, 2 load
    logic        hit;
    logic        blk;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        rdy;
    logic        e_dv;
    logic [31:0] e_daddr;
    logic [31:0] e_ddata;
    logic        e_fwd;
    logic [31:0] e_ldata;
    logic        e_drn;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input int op, input logic hit, input logic blk,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] be, input logic rdy,
                              input logic dv, input logic [31:0] da,
                              input logic [31:0] dd, input logic fwd,
                              input logic [31:0] ldv, input logic drn,
                              input logic fl, input logic em);
    vec_t v;
    v.op = op; v.hit = hit; v.blk = blk; v.addr = a; v.data = d; v.be = be;
    v.rdy = rdy; v.e_dv = dv; v.e_daddr = da; v.e_ddata = dd; v.e_fwd = fwd;
    v.e_ldata = ldv; v.e_drn = drn; v.e_full = fl; v.e_empty = em;
    return v;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input int op, input logic hit, input logic blk,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic rdy);
    valid_mem_i   = (op != 0);
    dc_wr_i       = (op == 1);
    dc_rd_i       = (op == 2);
    dc_hit_i      = hit;
    block_mem_i   = blk;
    addr_i        = a;
    data_i        = d;
    be_i          = be;
    drain_ready_i = rdy;
    flush_i       = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    set_in(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rdy);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic rdy);
    set_in(1, 1'b1, 1'b0, a, d, be, rdy);
  endtask

  initial begin
    rsn_i = 1'b0;
    idle(1'b0);

    tbl[0]  = mk(1,1,0,32'h100,32'hAABBCCDD,4'hF,1, 0,32'h0,  32'h0,       0,32'h0,       0,0,1);
    tbl[1]  = mk(1,1,0,32'h200,32'h55667788,4'hF,1, 1,32'h100,32'hAABBCCDD,0,32'h0,       0,0,0);
    tbl[2]  = mk(0,0,0,32'h0,  32'h0,       4'h0,1, 1,32'h200,32'h55667788,0,32'h0,       0,0,0);
    tbl[3]  = mk(0,0,0,32'h0,  32'h0,       4'h0,1, 0,32'h0,  32'h0,       0,32'h0,       0,0,1);
    tbl[4]  = mk(1,1,0,32'h100,32'h11223344,4'hF,0, 0,32'h0,  32'h0,       0,32'h0,       0,0,1);
    tbl[5]  = mk(2,1,0,32'h100,32'h0,       4'h3,0, 0,32'h0,  32'h0,       1,32'h00003344,0,0,0);
    tbl[6]  = mk(0,0,0,32'h0,  32'h0,       4'h0,1, 1,32'h100,32'h11223344,0,32'h0,       0,0,0);
    tbl[7]  = mk(1,1,0,32'h104,32'h000000EE,4'h1,0, 0,32'h0,  32'h0,       0,32'h0,       0,0,1);
    tbl[8]  = mk(2,1,0,32'h106,32'h0,       4'hF,0, 1,32'h104,32'h000000EE,0,32'h0,       1,0,0);
    tbl[9]  = mk(2,1,0,32'h106,32'h0,       4'hF,1, 1,32'h104,32'h000000EE,0,32'h0,       1,0,0);
    tbl[10] = mk(2,1,0,32'h106,32'h0,       4'hF,1, 0,32'h0,  32'h0,       0,32'h0,       0,0,1);
    tbl[11] = mk(1,1,0,32'h300,32'hDEADBEEF,4'h0,0, 0,32'h0,  32'h0,       0,32'h0,       0,0,1);
    tbl[12] = mk(1,0,0,32'h300,32'hDEADBEEF,4'hF,0, 0,32'h0,  32'h0,       0,32'h0,       0,0,1);
    tbl[13] = mk(1,1,1,32'h300,32'hDEADBEEF,4'hF,0, 0,32'h0,  32'h0,       0,32'h0,       0,0,1);
    tbl[14] = mk(0,0,0,32'h0,  32'h0,       4'h0,0, 0,32'h0,  32'h0,       0,32'h0,       0,0,1);

    // Reset state with a load pending on the inputs.
    @(negedge clk_i);
    set_in(2, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b1);
    #2;
    chk("rst drain_valid", 32'(drain_valid_o), 32'h0);
    chk("rst drain_addr",  drain_addr_o,       32'h0);
    chk("rst ld_fwd",      32'(ld_fwd_o),      32'h0);
    chk("rst draining",    32'(draining_o),    32'h0);
    chk("rst full",        32'(full_o),        32'h0);
    chk("rst empty",       32'(empty_o),       32'h1);
    @(negedge clk_i);
    rsn_i = 1'b1;
    idle(1'b0);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk_i);
      set_in(tbl[i].op, tbl[i].hit, tbl[i].blk, tbl[i].addr, tbl[i].data, tbl[i].be, tbl[i].rdy);
      #2;
      chk($sformatf("v%0d drain_valid", i), 32'(drain_valid_o), 32'(tbl[i].e_dv));
      if (tbl[i].e_dv) begin
        chk($sformatf("v%0d drain_addr", i), drain_addr_o, tbl[i].e_daddr);
        chk($sformatf("v%0d drain_data", i), drain_data_o, tbl[i].e_ddata);
      end
      chk($sformatf("v%0d ld_fwd", i), 32'(ld_fwd_o), 32'(tbl[i].e_fwd));
      if (tbl[i].e_fwd)
        chk($sformatf("v%0d ld_data", i), ld_data_o & lane_mask(tbl[i].be), tbl[i].e_ldata);
      chk($sformatf("v%0d draining", i), 32'(draining_o), 32'(tbl[i].e_drn));
      chk($sformatf("v%0d full", i),     32'(full_o),     32'(tbl[i].e_full));
      chk($sformatf("v%0d empty", i),    32'(empty_o),    32'(tbl[i].e_empty));
    end

    // Full stall, acceptance after a pop, merge into youngest while full.
    @(negedge clk_i); store(32'h400, 32'hA0A0A0A0, 4'hF, 1'b0); #2;
    chk("fm empty0", 32'(empty_o), 32'h1);
    @(negedge clk_i); store(32'h500, 32'h000000B1, 4'h1, 1'b0); #2;
    chk("fm full1", 32'(full_o), 32'h0);
    @(negedge clk_i); store(32'h600, 32'h000000C1, 4'h1, 1'b0); #2;
    chk("fm full2", 32'(full_o), 32'h1);
    chk("fm stall", 32'(draining_o), 32'h1);
    @(negedge clk_i); store(32'h600, 32'h000000C1, 4'h1, 1'b0); #2;
    chk("fm hold full", 32'(full_o), 32'h1);
    chk("fm hold stall", 32'(draining_o), 32'h1);
    @(negedge clk_i); store(32'h600, 32'h000000C1, 4'h1, 1'b1); #2;
    chk("fm pop stall", 32'(draining_o), 32'h1);
    chk("fm pop addr", drain_addr_o, 32'h400);
    @(negedge clk_i); store(32'h600, 32'h000000C1, 4'h1, 1'b0); #2;
    chk("fm after pop full", 32'(full_o), 32'h0);
    chk("fm after pop stall", 32'(draining_o), 32'h0);
    chk("fm after pop head", drain_addr_o, 32'h500);
    @(negedge clk_i); store(32'h600, 32'h0000D200, 4'h2, 1'b0); #2;
    chk("fm accepted", 32'(full_o), 32'h1);
    chk("fm merge nostall", 32'(draining_o), 32'h0);
    @(negedge clk_i); set_in(2, 1'b1, 1'b0, 32'h600, 32'h0, 4'h3, 1'b0); #2;
    chk("fm merge count", 32'(full_o), 32'h1);
    chk("fm merge fwd", 32'(ld_fwd_o), 32'h1);
    chk("fm merge ldata", ld_data_o & 32'h0000FFFF, 32'h0000D2C1);
    @(negedge clk_i); idle(1'b1); #2;
    chk("fm drain1 addr", drain_addr_o, 32'h500);
    chk("fm drain1 be", 32'(drain_be_o), 32'h1);
    chk("fm drain1 data", drain_data_o & 32'h000000FF, 32'h000000B1);
    @(negedge clk_i); idle(1'b1); #2;
    chk("fm drain2 addr", drain_addr_o, 32'h600);
    chk("fm drain2 be", 32'(drain_be_o), 32'h3);
    chk("fm drain2 data", drain_data_o & 32'h0000FFFF, 32'h0000D2C1);
    @(negedge clk_i); idle(1'b0); #2;
    chk("fm empty end", 32'(empty_o), 32'h1);

    // Flush with drain_ready toggling, then a flush pulse while empty.
    @(negedge clk_i); store(32'h700, 32'h00000077, 4'hF, 1'b0); #2;
    @(negedge clk_i); store(32'h800, 32'h00000088, 4'hF, 1'b0); #2;
    @(negedge clk_i); idle(1'b0); flush_i = 1'b1; #2;
    chk("fl full", 32'(full_o), 32'h1);
    @(negedge clk_i); idle(1'b1); #2;
    chk("fl drn r1", 32'(draining_o), 32'h1);
    chk("fl pop1 addr", drain_addr_o, 32'h700);
    @(negedge clk_i); idle(1'b0); #2;
    chk("fl drn r0", 32'(draining_o), 32'h1);
    chk("fl head2", drain_addr_o, 32'h800);
    @(negedge clk_i); idle(1'b1); #2;
    chk("fl drn r1b", 32'(draining_o), 32'h1);
    @(negedge clk_i); idle(1'b0); #2;
    chk("fl drn done", 32'(draining_o), 32'h0);
    chk("fl empty", 32'(empty_o), 32'h1);
    @(negedge clk_i); idle(1'b0); flush_i = 1'b1; #2;
    chk("fl empty pulse", 32'(draining_o), 32'h0);
    @(negedge clk_i); store(32'h900, 32'h00000099, 4'hF, 1'b0); #2;
    chk("fl st drn", 32'(draining_o), 32'h0);
    @(negedge clk_i); idle(1'b0); #2;
    chk("fl no stale", 32'(draining_o), 32'h0);
    chk("fl held", 32'(empty_o), 32'h0);
    @(negedge clk_i); idle(1'b1); #2;
    chk("fl drain 900", drain_addr_o, 32'h900);
    @(negedge clk_i); idle(1'b0); #2;
    chk("fl empty2", 32'(empty_o), 32'h1);

    // Asynchronous reset while two entries are draining.
    @(negedge clk_i); store(32'hA00, 32'h000000AA, 4'hF, 1'b0);
    @(negedge clk_i); store(32'hB00, 32'h000000BB, 4'hF, 1'b0);
    @(negedge clk_i); idle(1'b1); #2;
    chk("ar pre dv", 32'(drain_valid_o), 32'h1);
    chk("ar pre full", 32'(full_o), 32'h1);
    #1 rsn_i = 1'b0;
    #1;
    chk("ar dv", 32'(drain_valid_o), 32'h0);
    chk("ar addr", drain_addr_o, 32'h0);
    chk("ar data", drain_data_o, 32'h0);
    chk("ar be", 32'(drain_be_o), 32'h0);
    chk("ar full", 32'(full_o), 32'h0);
    chk("ar empty", 32'(empty_o), 32'h1);
    chk("ar drn", 32'(draining_o), 32'h0);
    @(negedge clk_i); rsn_i = 1'b1; idle(1'b0);
    @(negedge clk_i); store(32'hC00, 32'h000000CC, 4'hF, 1'b0); #2;
    chk("ar post empty", 32'(empty_o), 32'h1);
    @(negedge clk_i); idle(1'b1); #2;
    chk("ar first addr", drain_addr_o, 32'hC00);
    chk("ar first data", drain_data_o, 32'h000000CC);
    @(negedge clk_i); idle(1'b0); #2;
    chk("ar end empty", 32'(empty_o), 32'h1);

    // Five push/pop pairs so both pointers wrap several times.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_i);
      if (k < 5) store(32'h1000 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 4'hF, 1'b1);
      else       idle(1'b1);
      #2;
      if (k > 0) begin
        chk($sformatf("wr%0d dv", k),   32'(drain_valid_o), 32'h1);
        chk($sformatf("wr%0d addr", k), drain_addr_o, 32'h1000 + 32'(4 * (k - 1)));
        chk($sformatf("wr%0d data", k), drain_data_o, 32'hC0DE0000 + 32'(k - 1));
      end
    end
    @(negedge clk_i); idle(1'b0); #2;
    chk("wr empty", 32'(empty_o), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
